avmm_pio_bank: RTL and testbench

- Parametrised Avalon-MM PIO bank replacing the separate fixed-width LED, 7-segment and switch PIOs in the platform.
- Provides N_OUT output channels and N_IN input channels, each DATA_W bits wide.
- Inputs pass through a synchronizer and a per-channel debounce stage, feeding edge capture and a maskable, level-sensitive interrupt.
- Sits on the HPS lightweight bridge; all register access is single-cycle with fixed read latency 1.

---
 rtl/avmm_pio_pkg.sv | 25 ++
 rtl/pio_in_chan.sv | 82 ++++++++
 rtl/avmm_pio_bank.sv | 126 ++++++++++++
 tb/tb_avmm_pio_bank.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/avmm_pio_pkg.sv
// Shared constants and helpers for the Avalon-MM PIO bank.
//   REG_*  : per-channel register offsets (low two address bits)
//   EDGE_* : edge-capture mode encodings
//   clog2  : ceil(log2(v)), clog2(1) = 0
package avmm_pio_pkg;

  localparam logic [1:0] REG_DATA  = 2'd0;
  localparam logic [1:0] REG_MASK  = 2'd1;
  localparam logic [1:0] REG_EDGE  = 2'd2;
  localparam logic [1:0] REG_OUTRB = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pio_in_chan.sv
// One input channel: synchronizer, debounce counter, stable register and
// edge detect.
//   clk, rst_n  : clock, async active-low reset
//   din         : asynchronous channel input
//   stable      : debounced value (registered)
//   edge_pulse  : edges detected on the update about to be taken this cycle
module pio_in_chan
  import avmm_pio_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter int unsigned EDGE_MODE    = EDGE_RISE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] stable,
  output logic [DATA_W-1:0] edge_pulse
);

  localparam int unsigned CNT_RAW = clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned CNT_W   = (CNT_RAW > 0) ? CNT_RAW : 1;

  logic [DATA_W-1:0] sync_q [SYNC_STAGES];
  logic [DATA_W-1:0] sync_s;
  logic [DATA_W-1:0] sync_prev_q;
  logic [DATA_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign stable = stable_q;

  // Synchronizer chain plus the previous-sample register used by debounce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_prev_q <= '0;
    end else begin
      sync_q[0] <= din;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_prev_q <= sync_s;
    end
  end

  // Accept sync_s once it has held a new value for DEBOUNCE_CYC cycles
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (DEBOUNCE_CYC == 0) begin
      stable_d = sync_s;
    end else if ((sync_s != sync_prev_q) || (sync_s == stable_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
      stable_d = sync_s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Edge qualification on the stable value transition
  always_comb begin
    edge_pulse = '0;
    case (EDGE_MODE)
      EDGE_RISE: edge_pulse = stable_d & ~stable_q;
      EDGE_FALL: edge_pulse = ~stable_d & stable_q;
      default:   edge_pulse = stable_d ^ stable_q;
    endcase
  end

endmodule

// File: rtl/avmm_pio_bank.sv
// Parametrised Avalon-MM PIO bank: N_OUT output and N_IN debounced input
// channels with edge capture and a maskable level interrupt.
//   clk_clk, reset_reset_n : clock, async active-low reset
//   avs_*                  : Avalon-MM slave, address = {channel, reg},
//                            fixed read latency 1
//   irq                    : OR over channels of (EDGE_CAP & IRQ_MASK)
//   pio_out / pio_in       : channel k at bits [k*DATA_W +: DATA_W]
module avmm_pio_bank
  import avmm_pio_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned N_OUT        = 2,
  parameter int unsigned N_IN         = 1,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter int unsigned EDGE_MODE    = 0,
  parameter int unsigned OUT_RESET    = 0,
  localparam int unsigned CH_MAX = (N_OUT > N_IN) ? N_OUT : N_IN,
  localparam int unsigned CH_W   = (clog2(CH_MAX) > 1) ? clog2(CH_MAX) : 1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [CH_W+1:0]         avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  output logic                    irq,
  output logic [N_OUT*DATA_W-1:0] pio_out,
  input  logic [N_IN*DATA_W-1:0]  pio_in
);

  logic [CH_W-1:0]   ch;
  logic [1:0]        sel;
  logic [DATA_W-1:0] wdata;
  logic              unused_wdata;

  logic [DATA_W-1:0] stable_w [N_IN];
  logic [DATA_W-1:0] edge_w   [N_IN];
  logic [DATA_W-1:0] w1c_c    [N_IN];
  logic [DATA_W-1:0] mask_q   [N_IN];
  logic [DATA_W-1:0] edge_q   [N_IN];
  logic [DATA_W-1:0] rd_val_c;
  logic              irq_c;

  assign ch           = avs_address[CH_W+1:2];
  assign sel          = avs_address[1:0];
  assign wdata        = avs_writedata[DATA_W-1:0];
  assign unused_wdata = ^avs_writedata;

  for (genvar c = 0; c < N_IN; c++) begin : g_in
    pio_in_chan #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .EDGE_MODE   (EDGE_MODE)
    ) u_chan (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .din       (pio_in[c*DATA_W +: DATA_W]),
      .stable    (stable_w[c]),
      .edge_pulse(edge_w[c])
    );
  end

  // Output channel registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pio_out <= {N_OUT{DATA_W'(OUT_RESET)}};
    end else if (avs_write && (sel == REG_DATA)) begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (ch == CH_W'(k)) pio_out[k*DATA_W +: DATA_W] <= wdata;
      end
    end
  end

  // Per-channel W1C clear vector and interrupt reduction
  always_comb begin
    irq_c = 1'b0;
    for (int unsigned c = 0; c < N_IN; c++) begin
      w1c_c[c] = (avs_write && (sel == REG_EDGE) && (ch == CH_W'(c))) ? wdata : '0;
      irq_c    = irq_c | (|(edge_q[c] & mask_q[c]));
    end
  end

  // Mask and edge-capture registers; a new edge overrides a same-cycle clear
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned c = 0; c < N_IN; c++) begin
        mask_q[c] <= '0;
        edge_q[c] <= '0;
      end
      irq <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < N_IN; c++) begin
        if (avs_write && (sel == REG_MASK) && (ch == CH_W'(c))) mask_q[c] <= wdata;
        edge_q[c] <= (edge_q[c] & ~w1c_c[c]) | edge_w[c];
      end
      irq <= irq_c;
    end
  end

  // Read mux; nonexistent channels fall through to zero
  always_comb begin
    rd_val_c = '0;
    for (int unsigned c = 0; c < N_IN; c++) begin
      if (ch == CH_W'(c)) begin
        case (sel)
          REG_DATA: rd_val_c = stable_w[c];
          REG_MASK: rd_val_c = mask_q[c];
          REG_EDGE: rd_val_c = edge_q[c];
          default:  ;
        endcase
      end
    end
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if ((sel == REG_OUTRB) && (ch == CH_W'(k))) rd_val_c = pio_out[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) avs_readdata <= '0;
    else if (avs_read)  avs_readdata <= 32'(rd_val_c);
  end

endmodule

// File: tb/tb_avmm_pio_bank.sv
// Directed bench for avmm_pio_bank: one rising-edge instance and one
// both-edge instance sharing bus, clock, reset and inputs.
module tb_avmm_pio_bank;
  import avmm_pio_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;
  logic [15:0] pio_out_a, pio_out_b;
  logic [39:0] pio_in;

  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  avmm_pio_bank #(
    .DATA_W(8), .N_OUT(2), .N_IN(5), .SYNC_STAGES(2), .DEBOUNCE_CYC(4),
    .EDGE_MODE(0), .OUT_RESET(32'hA5)
  ) u_dut_rise (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(rdata_a), .irq(irq_a), .pio_out(pio_out_a), .pio_in(pio_in)
  );

  avmm_pio_bank #(
    .DATA_W(8), .N_OUT(2), .N_IN(5), .SYNC_STAGES(2), .DEBOUNCE_CYC(4),
    .EDGE_MODE(2), .OUT_RESET(32'hA5)
  ) u_dut_both (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(rdata_b), .irq(irq_b), .pio_out(pio_out_b), .pio_in(pio_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] ch, input logic [1:0] rg, input logic [31:0] d);
    avs_address   = {ch, rg};
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] ch, input logic [1:0] rg);
    avs_address = {ch, rg};
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; pio_in = '0;
    wait_cyc(3);
    check("rst_pio_out_a", 32'(pio_out_a), 32'h0000_A5A5);
    check("rst_pio_out_b", 32'(pio_out_b), 32'h0000_A5A5);
    check("rst_irq", 32'(irq_a), 32'h0);
    check("rst_readdata", rdata_a, 32'h0);

    rst_n = 1'b1;
    pio_in[39:32] = 8'hC3;
    tick();
    bus_read(3'd1, REG_OUTRB);          check("rd_ch1_outrb_rst", rdata_a, 32'hA5);
    bus_write(3'd1, REG_DATA, 32'h3C);  check("wr_ch1_data", 32'(pio_out_a), 32'h0000_3CA5);
    bus_read(3'd7, REG_DATA);           check("rd_ch7_data", rdata_a, 32'h0);
    bus_write(3'd7, REG_DATA, 32'hFF);  check("wr_ch7_ignored", 32'(pio_out_a), 32'h0000_3CA5);
    bus_write(3'd2, REG_DATA, 32'h11);  check("wr_ch2_ignored", 32'(pio_out_a), 32'h0000_3CA5);
    bus_write(3'd0, REG_DATA, 32'hFFFF_FF5A);
    check("wr_upper_bits_ignored", 32'(pio_out_a), 32'h0000_3C5A);
    bus_read(3'd4, REG_DATA);           check("rd_ch4_data", rdata_a, 32'hC3);
    bus_read(3'd5, REG_DATA);           check("rd_ch5_data_oor", rdata_a, 32'h0);
    bus_read(3'd0, REG_OUTRB);          check("rd_ch0_outrb", rdata_a, 32'h5A);
    bus_read(3'd2, REG_OUTRB);          check("rd_ch2_outrb_oor", rdata_a, 32'h0);

    // Simultaneous read and write of the same register returns the old value
    bus_read(3'd1, REG_OUTRB);          check("rd_ch1_outrb", rdata_a, 32'h3C);
    avs_address = {3'd1, REG_MASK}; avs_writedata = 32'h77;
    avs_read = 1'b1; avs_write = 1'b1;
    tick();
    avs_read = 1'b0; avs_write = 1'b0;
    check("rw_same_reg_old", rdata_a, 32'h0);
    bus_read(3'd1, REG_MASK);           check("rd_ch1_mask", rdata_a, 32'h77);

    // Three-cycle glitch is rejected
    pio_in[0] = 1'b1;
    wait_cyc(3);
    pio_in[0] = 1'b0;
    wait_cyc(8);
    bus_read(3'd0, REG_DATA);           check("glitch_data", rdata_a, 32'h0);
    bus_read(3'd0, REG_EDGE);           check("glitch_edge", rdata_a, 32'h0);

    // Clean change: stable updates at the 7th edge after the change
    pio_in[0] = 1'b1;
    wait_cyc(6);
    bus_read(3'd0, REG_DATA);           check("deb_edge7_old", rdata_a, 32'h0);
    bus_read(3'd0, REG_DATA);           check("deb_edge8_new", rdata_a, 32'h1);
    bus_read(3'd0, REG_EDGE);
    check("edge_bit0_a", rdata_a, 32'h1);
    check("edge_bit0_b", rdata_b, 32'h1);
    check("irq_unmasked", 32'(irq_a), 32'h0);

    // Interrupt follows mask write and W1C with one cycle of latency
    bus_write(3'd0, REG_MASK, 32'h01);  check("irq_mask_same_edge", 32'(irq_a), 32'h0);
    tick();                             check("irq_after_mask", 32'(irq_a), 32'h1);
    bus_write(3'd0, REG_EDGE, 32'h01);  check("irq_w1c_same_edge", 32'(irq_a), 32'h1);
    tick();                             check("irq_after_w1c", 32'(irq_a), 32'h0);

    // Falling edge: only the both-edge instance captures it
    pio_in[0] = 1'b0;
    wait_cyc(10);
    check("irq_b_fall", 32'(irq_b), 32'h1);
    bus_read(3'd0, REG_EDGE);
    check("fall_edge_a", rdata_a, 32'h0);
    check("fall_edge_b", rdata_b, 32'h1);
    bus_write(3'd0, REG_EDGE, 32'hFF);

    // Rising edge on masked bit0
    pio_in[0] = 1'b1;
    wait_cyc(7);
    check("irq_capture_edge", 32'(irq_a), 32'h0);
    tick();
    check("irq_next_cycle", 32'(irq_a), 32'h1);
    bus_write(3'd0, REG_EDGE, 32'h01);
    tick();
    check("irq_cleared", 32'(irq_a), 32'h0);

    // Rising edge on unmasked bit1
    pio_in[1] = 1'b1;
    wait_cyc(10);
    bus_read(3'd0, REG_EDGE);           check("edge_bit1_a", rdata_a, 32'h02);
    check("irq_bit1_unmasked", 32'(irq_a), 32'h0);

    // Bit3 rise then fall
    bus_write(3'd0, REG_EDGE, 32'hFF);
    pio_in[3] = 1'b1;
    wait_cyc(10);
    bus_read(3'd0, REG_EDGE);
    check("bit3_rise_a", rdata_a, 32'h08);
    check("bit3_rise_b", rdata_b, 32'h08);
    bus_write(3'd0, REG_EDGE, 32'h08);
    pio_in[3] = 1'b0;
    wait_cyc(10);
    bus_read(3'd0, REG_EDGE);
    check("bit3_fall_a", rdata_a, 32'h00);
    check("bit3_fall_b", rdata_b, 32'h08);

    // W1C landing on the same edge as a new capture: edge wins
    pio_in[3] = 1'b1;
    wait_cyc(6);
    bus_write(3'd0, REG_EDGE, 32'h08);
    bus_read(3'd0, REG_EDGE);
    check("w1c_vs_edge_a", rdata_a, 32'h08);
    check("w1c_vs_edge_b", rdata_b, 32'h08);

    // Asynchronous reset mid-debounce with irq asserted
    bus_write(3'd0, REG_MASK, 32'h08);
    tick();
    check("irq_pre_reset", 32'(irq_a), 32'h1);
    bus_read(3'd1, REG_OUTRB);          check("rd_pre_reset", rdata_a, 32'h3C);
    pio_in[7:0] = 8'h00;
    wait_cyc(4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_irq", 32'(irq_a), 32'h0);
    check("async_rst_pio_out", 32'(pio_out_a), 32'h0000_A5A5);
    check("async_rst_readdata", rdata_a, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pio_in[7:0] = 8'h01;
    wait_cyc(6);
    bus_read(3'd0, REG_DATA);           check("post_rst_edge7_old", rdata_a, 32'h0);
    bus_read(3'd0, REG_DATA);           check("post_rst_edge8_new", rdata_a, 32'h1);
    bus_read(3'd0, REG_MASK);           check("post_rst_mask", rdata_a, 32'h0);
    check("post_rst_irq", 32'(irq_a), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
